bubbledrive8_fifo_tx: RTL and testbench
=======================================

BUBBLEDRIVE8_FIFO_TX -- requirements
Module: bubbledrive8_fifo_tx

Interface
REQ-001 The block SHALL take parameter BOOTLEN, default 64, meaning boot page payload bytes.
REQ-002 The block SHALL take parameter USERLEN, default 128, meaning user page payload bytes.
REQ-003 The block SHALL take parameter HDR_BOOT, default 8'hB0, meaning boot frame header byte.
REQ-004 The block SHALL take parameter HDR_USER, default 8'hC0, meaning user frame header byte.
REQ-005 The block SHALL have port MCLK, input, 1, the 48 MHz clock; the single clock, all logic on its rising edge.
REQ-006 The block SHALL have port MRST, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port nEN, input, 1, active-low block enable.
REQ-008 The block SHALL have port nFIFOBUFWRCLKEN, input, 1, active-low bit-write strobe.
REQ-009 The block SHALL have port FIFOBUFWRADDR, input, 13, bit address.
REQ-010 The block SHALL have port FIFOBUFWRDATA, input, 1, bit data.
REQ-011 The block SHALL have ports nFIFOSENDBOOT and nFIFOSENDUSER, input, 1 each, active-low send requests.
REQ-012 The block SHALL have port FIFORELPAGE, input, 12, relative page number.
REQ-013 The block SHALL have port nTXE, input, 1, FT232 transmit FIFO has room when low.
REQ-014 The block SHALL have ports nWR (output, 1, FT232 write strobe), DOUT (output, 8, byte data), DOEN (output, 1, ADBUS drive enable) and BUSY (output, 1, frame in progress).

Function
REQ-015 Buffer: the block SHALL hold 8192x1 bits and write FIFOBUFWRDATA to FIFOBUFWRADDR on every cycle with nFIFOBUFWRCLKEN=0 and nEN=0, in any state.
REQ-016 Buffer reads SHALL be synchronous with 1-cycle latency; a read and a write to the same address in one cycle SHALL return the old bit.
REQ-017 Requests SHALL be falling-edge detected: registered previous value, reset value 1.
REQ-018 Requests SHALL be accepted only in IDLE; edges while BUSY=1 SHALL be discarded, not queued.
REQ-019 Simultaneous boot and user edges SHALL start a boot frame; the user edge SHALL be dropped.
REQ-020 The acceptance cycle SHALL latch kind and FIFORELPAGE and set BUSY=1 on the next edge.
REQ-021 Frame order: HDR (HDR_BOOT or HDR_USER), then {4'h0, RELPAGE[11:8]}, then RELPAGE[7:0], then payload bytes 0..LEN-1, where LEN is BOOTLEN or USERLEN.
REQ-022 Payload byte k SHALL be assembled from bit addresses 8k..8k+7, with address 8k mapped to DOUT[7] (MSB first).
REQ-023 Payload assembly SHALL take LOAD, 9 cycles (8 reads plus latency), before each payload byte.
REQ-024 States: IDLE -> [LOAD] -> WAITTXE -> SETUP -> STRB -> HOLD -> (next byte | IDLE).
REQ-025 WAITTXE SHALL stay until nTXE is sampled 0, with no timeout.
REQ-026 SETUP SHALL last 1 cycle with DOEN=1 and DOUT valid and nWR=1.
REQ-027 STRB SHALL last exactly 2 cycles with nWR=0 and DOUT held.
REQ-028 HOLD SHALL last 1 cycle with nWR=1 and DOUT held.
REQ-029 DOEN SHALL be 1 from SETUP through HOLD and 0 otherwise.
REQ-030 After the HOLD of the last byte, the block SHALL return to IDLE with BUSY=0 on the following edge.
REQ-031 Byte counter width SHALL cover USERLEN+3 without wrap; bit address width SHALL be 13; a payload exceeding 8192 bits SHALL wrap modulo 8192.
REQ-032 nEN=1 in any state SHALL force IDLE next edge with nWR=1, DOEN=0, BUSY=0; the partial frame is abandoned and no resume occurs.

Reset
REQ-033 MRST=1 SHALL, on the next edge, set IDLE, nWR=1, DOEN=0, DOUT=8'h00, BUSY=0, request edge registers=1 and counters=0.
REQ-034 Reset SHALL override nEN, requests and writes; buffer contents SHALL be unspecified and not cleared.
REQ-035 Reset asserted mid-strobe SHALL release nWR high on the next edge.

Verification
REQ-036 Fill bits 0..511 with pattern 0xA5 per byte, RELPAGE=12'h123, pulse nFIFOSENDBOOT, nTXE=0 -> 67 bytes B0,01,23,A5x64; each nWR low exactly 2 cycles; BUSY falls after the last HOLD.
REQ-037 User send with RELPAGE=12'hFFF and bytes 0..127 = k -> C0,0F,FF,00..7F; 131 strobes.
REQ-038 nTXE=1 held for 100 cycles before byte 5 -> nWR stays 1 and DOUT/DOEN stay stable; the frame resumes correctly when nTXE falls.
REQ-039 Both requests fall on the same cycle, then a user edge arrives mid-frame -> exactly one boot frame, with no user frame.
REQ-040 nEN raised during payload byte 10 -> next edge nWR=1, DOEN=0, BUSY=0; a later request produces a full fresh frame.
REQ-041 MRST pulsed while nWR=0 -> nWR=1 and all outputs at reset values on the next edge.

Source files
------------

// File: rtl/bubbledrive8_fifo_tx.sv
// bubbledrive8_fifo_tx
// Serialises a boot or user page out of an 8192x1 bit buffer to an FT232
// in synchronous-FIFO style. Each frame is a header byte, two relative-page
// bytes, then the page payload. Payload bytes are gathered MSB first from
// consecutive bit addresses.
//
// Ports
//   MCLK             single clock, all logic on its rising edge
//   MRST             synchronous active-high reset
//   nEN              active-low block enable (high aborts any frame)
//   nFIFOBUFWRCLKEN  active-low bit-write strobe for the buffer
//   FIFOBUFWRADDR    13-bit buffer bit address
//   FIFOBUFWRDATA    buffer write bit
//   nFIFOSENDBOOT    active-low boot page send request (falling edge)
//   nFIFOSENDUSER    active-low user page send request (falling edge)
//   FIFORELPAGE      12-bit relative page number sent in the frame
//   nTXE             FT232 transmit FIFO has room when low
//   nWR              FT232 write strobe, active low
//   DOUT             byte presented on ADBUS
//   DOEN             ADBUS drive enable
//   BUSY             a frame is in progress
module bubbledrive8_fifo_tx #(
    parameter int         BOOTLEN  = 64,
    parameter int         USERLEN  = 128,
    parameter logic [7:0] HDR_BOOT = 8'hB0,
    parameter logic [7:0] HDR_USER = 8'hC0
) (
    input  logic        MCLK,
    input  logic        MRST,
    input  logic        nEN,
    input  logic        nFIFOBUFWRCLKEN,
    input  logic [12:0] FIFOBUFWRADDR,
    input  logic        FIFOBUFWRDATA,
    input  logic        nFIFOSENDBOOT,
    input  logic        nFIFOSENDUSER,
    input  logic [11:0] FIFORELPAGE,
    input  logic        nTXE,
    output logic        nWR,
    output logic [7:0]  DOUT,
    output logic        DOEN,
    output logic        BUSY
);

    localparam int MAXLEN = (USERLEN > BOOTLEN) ? USERLEN : BOOTLEN;
    // Holds frame byte indices 0 .. MAXLEN+2 without wrapping.
    localparam int CNTW = $clog2(MAXLEN + 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAITTXE,
        S_SETUP,
        S_STRB,
        S_HOLD
    } state_t;

    logic            mem [0:8191];
    logic            rdBit_q;

    state_t          state_q,    state_d;
    logic            isBoot_q,   isBoot_d;
    logic [11:0]     page_q,     page_d;
    logic [CNTW-1:0] byteCnt_q,  byteCnt_d;
    logic [12:0]     bitAddr_q,  bitAddr_d;
    logic [3:0]      loadCnt_q,  loadCnt_d;
    logic [7:0]      shift_q,    shift_d;
    logic [7:0]      dout_q,     dout_d;
    logic            strbCnt_q,  strbCnt_d;
    logic            bootPrev_q, bootPrev_d;
    logic            userPrev_q, userPrev_d;

    logic            bootFall;
    logic            userFall;
    logic [CNTW-1:0] lastIdx;
    logic [7:0]      byteValue;

    // Bit buffer. The read uses the pre-write contents, so a same-address
    // read/write returns the old bit. Contents survive reset.
    always_ff @(posedge MCLK) begin
        if (!MRST && !nEN && !nFIFOBUFWRCLKEN) begin
            mem[FIFOBUFWRADDR] <= FIFOBUFWRDATA;
        end
        rdBit_q <= mem[bitAddr_q];
    end

    always_ff @(posedge MCLK) begin
        if (MRST) begin
            state_q    <= S_IDLE;
            isBoot_q   <= 1'b0;
            page_q     <= '0;
            byteCnt_q  <= '0;
            bitAddr_q  <= '0;
            loadCnt_q  <= '0;
            shift_q    <= '0;
            dout_q     <= 8'h00;
            strbCnt_q  <= 1'b0;
            bootPrev_q <= 1'b1;
            userPrev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            isBoot_q   <= isBoot_d;
            page_q     <= page_d;
            byteCnt_q  <= byteCnt_d;
            bitAddr_q  <= bitAddr_d;
            loadCnt_q  <= loadCnt_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            strbCnt_q  <= strbCnt_d;
            bootPrev_q <= bootPrev_d;
            userPrev_q <= userPrev_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        isBoot_d   = isBoot_q;
        page_d     = page_q;
        byteCnt_d  = byteCnt_q;
        bitAddr_d  = bitAddr_q;
        loadCnt_d  = loadCnt_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        strbCnt_d  = strbCnt_q;
        bootPrev_d = nFIFOSENDBOOT;
        userPrev_d = nFIFOSENDUSER;

        bootFall = bootPrev_q & ~nFIFOSENDBOOT;
        userFall = userPrev_q & ~nFIFOSENDUSER;
        lastIdx  = isBoot_q ? CNTW'(BOOTLEN + 2) : CNTW'(USERLEN + 2);

        // Frame bytes 0..2 are header and page; the rest come from the
        // shift register filled during LOAD.
        if (byteCnt_q == CNTW'(0)) begin
            byteValue = isBoot_q ? HDR_BOOT : HDR_USER;
        end else if (byteCnt_q == CNTW'(1)) begin
            byteValue = {4'h0, page_q[11:8]};
        end else if (byteCnt_q == CNTW'(2)) begin
            byteValue = page_q[7:0];
        end else begin
            byteValue = shift_q;
        end

        case (state_q)
            S_IDLE: begin
                // Boot wins a tie; the user edge is simply lost.
                if (bootFall || userFall) begin
                    isBoot_d  = bootFall;
                    page_d    = FIFORELPAGE;
                    byteCnt_d = '0;
                    bitAddr_d = '0;
                    loadCnt_d = '0;
                    state_d   = S_WAITTXE;
                end
            end
            S_LOAD: begin
                // Addresses issue on counts 0..7; the bit read on count n
                // arrives on count n+1, so shifting runs on counts 1..8.
                if (loadCnt_q != 4'd0) begin
                    shift_d = {shift_q[6:0], rdBit_q};
                end
                if (loadCnt_q != 4'd8) begin
                    bitAddr_d = bitAddr_q + 13'd1;
                    loadCnt_d = loadCnt_q + 4'd1;
                end else begin
                    loadCnt_d = '0;
                    state_d   = S_WAITTXE;
                end
            end
            S_WAITTXE: begin
                if (!nTXE) begin
                    dout_d  = byteValue;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                strbCnt_d = 1'b0;
                state_d   = S_STRB;
            end
            S_STRB: begin
                if (strbCnt_q) begin
                    state_d = S_HOLD;
                end else begin
                    strbCnt_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (byteCnt_q == lastIdx) begin
                    state_d = S_IDLE;
                end else begin
                    byteCnt_d = byteCnt_q + CNTW'(1);
                    state_d   = (byteCnt_q >= CNTW'(2)) ? S_LOAD : S_WAITTXE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable abandons the frame outright; nothing is remembered.
        if (nEN) begin
            state_d   = S_IDLE;
            loadCnt_d = '0;
        end
    end

    assign nWR  = (state_q != S_STRB);
    assign DOEN = (state_q == S_SETUP) || (state_q == S_STRB) || (state_q == S_HOLD);
    assign BUSY = (state_q != S_IDLE);
    assign DOUT = dout_q;

endmodule

// File: tb/tb_bubbledrive8_fifo_tx.sv
// tb_bubbledrive8_fifo_tx
// Self-checking bench for bubbledrive8_fifo_tx. A reference copy of the bit
// buffer is kept here; expected frames are computed from it directly. A
// monitor records every strobed byte and strobe length and counts any bus
// protocol violation (setup/hold/DOEN).
//
// Ports: none (top-level bench).
module tb_bubbledrive8_fifo_tx;

    localparam int BOOTLEN = 64;
    localparam int USERLEN = 128;

    logic        MCLK;
    logic        MRST;
    logic        nEN;
    logic        nFIFOBUFWRCLKEN;
    logic [12:0] FIFOBUFWRADDR;
    logic        FIFOBUFWRDATA;
    logic        nFIFOSENDBOOT;
    logic        nFIFOSENDUSER;
    logic [11:0] FIFORELPAGE;
    logic        nTXE;
    logic        nWR;
    logic [7:0]  DOUT;
    logic        DOEN;
    logic        BUSY;

    bubbledrive8_fifo_tx #(
        .BOOTLEN (BOOTLEN),
        .USERLEN (USERLEN),
        .HDR_BOOT(8'hB0),
        .HDR_USER(8'hC0)
    ) dut (
        .MCLK           (MCLK),
        .MRST           (MRST),
        .nEN            (nEN),
        .nFIFOBUFWRCLKEN(nFIFOBUFWRCLKEN),
        .FIFOBUFWRADDR  (FIFOBUFWRADDR),
        .FIFOBUFWRDATA  (FIFOBUFWRDATA),
        .nFIFOSENDBOOT  (nFIFOSENDBOOT),
        .nFIFOSENDUSER  (nFIFOSENDUSER),
        .FIFORELPAGE    (FIFORELPAGE),
        .nTXE           (nTXE),
        .nWR            (nWR),
        .DOUT           (DOUT),
        .DOEN           (DOEN),
        .BUSY           (BUSY)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    bit         refMem [0:8191];
    logic [7:0] expQ [$];
    logic [7:0] capQ [$];
    int         lenQ [$];
    int         protoErr;
    int         checks;
    int         errors;

    logic       prevNwr  = 1'b1;
    logic       prevDoen = 1'b0;
    logic [7:0] prevDout = 8'h00;
    logic [7:0] strbDout = 8'h00;
    int         lowLen   = 0;

    // Bus monitor sampled on the falling edge.
    always @(negedge MCLK) begin
        if (MRST) begin
            lowLen = 0;
        end else begin
            if (nWR === 1'b0 && prevNwr === 1'b1) begin
                capQ.push_back(DOUT);
                strbDout = DOUT;
                lowLen   = 1;
                if (!(prevDoen === 1'b1 && prevDout === DOUT)) protoErr++;
            end else if (nWR === 1'b0) begin
                lowLen++;
                if (DOUT !== strbDout) protoErr++;
            end else if (nWR === 1'b1 && prevNwr === 1'b0) begin
                lenQ.push_back(lowLen);
                if (!(DOEN === 1'b1 && DOUT === strbDout)) protoErr++;
            end
            if (nWR === 1'b0 && DOEN !== 1'b1) protoErr++;
        end
        prevNwr  = nWR;
        prevDoen = DOEN;
        prevDout = DOUT;
    end

    // mode 0: constant A5, mode 1: byte index, mode 2: random
    task automatic fillBytes(input int nBytes, input int mode);
        logic [7:0] v;
        for (int k = 0; k < nBytes; k++) begin
            case (mode)
                0:       v = 8'hA5;
                1:       v = 8'(k);
                default: v = 8'($urandom);
            endcase
            for (int j = 0; j < 8; j++) begin
                @(negedge MCLK);
                nFIFOBUFWRCLKEN = 1'b0;
                FIFOBUFWRADDR   = 13'(8 * k + j);
                FIFOBUFWRDATA   = v[7-j];
                refMem[(8 * k + j) % 8192] = v[7-j];
            end
        end
        @(negedge MCLK);
        nFIFOBUFWRCLKEN = 1'b1;
    endtask

    task automatic buildExpected(input bit boot, input logic [11:0] page);
        logic [7:0] b;
        int len;
        len = boot ? BOOTLEN : USERLEN;
        expQ.delete();
        expQ.push_back(boot ? 8'hB0 : 8'hC0);
        expQ.push_back({4'h0, page[11:8]});
        expQ.push_back(page[7:0]);
        for (int k = 0; k < len; k++) begin
            for (int j = 0; j < 8; j++) b[7-j] = refMem[(8 * k + j) % 8192];
            expQ.push_back(b);
        end
    endtask

    task automatic clearCapture();
        capQ.delete();
        lenQ.delete();
        protoErr = 0;
    endtask

    task automatic pulseRequest(input bit boot, input bit user, input logic [11:0] page,
                                output logic busySeen);
        @(negedge MCLK);
        FIFORELPAGE = page;
        if (boot) nFIFOSENDBOOT = 1'b0;
        if (user) nFIFOSENDUSER = 1'b0;
        @(negedge MCLK);
        busySeen      = BUSY;
        nFIFOSENDBOOT = 1'b1;
        nFIFOSENDUSER = 1'b1;
    endtask

    task automatic waitIdle(input int budget, output bit timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge MCLK);
            if (BUSY === 1'b0) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic waitCount(input int n, input int budget, output bit timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge MCLK);
            if (capQ.size() >= n) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        MRST = 1'b1;
        repeat (3) @(negedge MCLK);
        checks++; if (nWR !== 1'b1)  begin errors++; $display("[TB] FAIL reset_nWR: got %b expected 1", nWR); end
        checks++; if (DOEN !== 1'b0) begin errors++; $display("[TB] FAIL reset_DOEN: got %b expected 0", DOEN); end
        checks++; if (DOUT !== 8'h00) begin errors++; $display("[TB] FAIL reset_DOUT: got %h expected 00", DOUT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_BUSY: got %b expected 0", BUSY); end
        MRST = 1'b0;
        repeat (2) @(negedge MCLK);
    endtask

    task automatic test_frames();
        bit          boot;
        logic [11:0] page;
        logic        busySeen;
        bit          to;
        int          badLen;
        for (int sc = 0; sc < 6; sc++) begin
            if (sc == 0) begin
                boot = 1'b1; page = 12'h123; fillBytes(BOOTLEN, 0);
            end else if (sc == 1) begin
                boot = 1'b0; page = 12'hFFF; fillBytes(USERLEN, 1);
            end else begin
                boot = 1'($urandom); page = 12'($urandom); fillBytes(USERLEN, 2);
            end
            buildExpected(boot, page);
            clearCapture();
            pulseRequest(boot, !boot, page, busySeen);
            checks++; if (busySeen !== 1'b1) begin errors++; $display("[TB] FAIL frame%0d_busy_rise: got %b expected 1", sc, busySeen); end
            waitIdle(5000, to);
            checks++; if (to) begin errors++; $display("[TB] FAIL frame%0d_timeout: BUSY still %b expected 0", sc, BUSY); end
            checks++; if (capQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL frame%0d_count: got %0d expected %0d", sc, capQ.size(), expQ.size()); end
            for (int i = 0; i < expQ.size() && i < capQ.size(); i++) begin
                checks++;
                if (capQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL frame%0d_byte%0d: got %h expected %h", sc, i, capQ[i], expQ[i]); end
            end
            badLen = 0;
            foreach (lenQ[i]) if (lenQ[i] != 2) badLen++;
            checks++; if (badLen != 0 || lenQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL frame%0d_strobe_len: %0d of %0d strobes not 2 cycles, expected %0d strobes", sc, badLen, lenQ.size(), expQ.size()); end
            checks++; if (protoErr != 0) begin errors++; $display("[TB] FAIL frame%0d_protocol: got %0d violations expected 0", sc, protoErr); end
        end
    endtask

    task automatic test_txe_stall();
        logic [11:0] page;
        logic        busySeen;
        bit          to;
        logic [7:0]  d0;
        logic        e0;
        int          n0;
        int          stableErr;
        page = 12'($urandom);
        buildExpected(1'b1, page);
        clearCapture();
        pulseRequest(1'b1, 1'b0, page, busySeen);
        waitCount(5, 500, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL stall_reach5: got %0d bytes expected 5", capQ.size()); end
        nTXE = 1'b1;
        repeat (14) @(negedge MCLK);
        d0 = DOUT; e0 = DOEN; n0 = capQ.size();
        stableErr = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge MCLK);
            if (nWR !== 1'b1 || DOUT !== d0 || DOEN !== e0) stableErr++;
        end
        checks++; if (stableErr != 0) begin errors++; $display("[TB] FAIL stall_stable: got %0d unstable cycles expected 0", stableErr); end
        checks++; if (e0 !== 1'b0) begin errors++; $display("[TB] FAIL stall_doen: got %b expected 0", e0); end
        checks++; if (n0 != 5 || capQ.size() != 5) begin errors++; $display("[TB] FAIL stall_no_strobe: got %0d bytes expected 5", capQ.size()); end
        nTXE = 1'b0;
        waitIdle(3000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL stall_timeout: BUSY %b expected 0", BUSY); end
        checks++; if (capQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL stall_count: got %0d expected %0d", capQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < capQ.size(); i++) begin
            checks++;
            if (capQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL stall_byte%0d: got %h expected %h", i, capQ[i], expQ[i]); end
        end
        checks++; if (protoErr != 0) begin errors++; $display("[TB] FAIL stall_protocol: got %0d violations expected 0", protoErr); end
    endtask

    task automatic test_simultaneous();
        logic [11:0] page;
        logic        busySeen;
        bit          to;
        int          n0;
        page = 12'($urandom);
        buildExpected(1'b1, page);
        clearCapture();
        pulseRequest(1'b1, 1'b1, page, busySeen);
        checks++; if (busySeen !== 1'b1) begin errors++; $display("[TB] FAIL simul_busy: got %b expected 1", busySeen); end
        waitCount(20, 1000, to);
        pulseRequest(1'b0, 1'b1, ~page, busySeen);
        waitIdle(3000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL simul_timeout: BUSY %b expected 0", BUSY); end
        checks++; if (capQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL simul_count: got %0d expected %0d", capQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < capQ.size(); i++) begin
            checks++;
            if (capQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL simul_byte%0d: got %h expected %h", i, capQ[i], expQ[i]); end
        end
        n0 = capQ.size();
        repeat (50) @(negedge MCLK);
        checks++; if (BUSY !== 1'b0 || capQ.size() != n0) begin errors++; $display("[TB] FAIL simul_no_user_frame: BUSY %b bytes %0d expected 0 and %0d", BUSY, capQ.size(), n0); end
    endtask

    task automatic test_disable();
        logic [11:0] page;
        logic        busySeen;
        bit          to;
        page = 12'($urandom);
        clearCapture();
        pulseRequest(1'b0, 1'b1, page, busySeen);
        waitCount(14, 2000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL dis_reach: got %0d bytes expected 14", capQ.size()); end
        nEN = 1'b1;
        @(negedge MCLK);
        checks++; if (nWR !== 1'b1)  begin errors++; $display("[TB] FAIL dis_nWR: got %b expected 1", nWR); end
        checks++; if (DOEN !== 1'b0) begin errors++; $display("[TB] FAIL dis_DOEN: got %b expected 0", DOEN); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL dis_BUSY: got %b expected 0", BUSY); end
        repeat (3) @(negedge MCLK);
        nEN = 1'b0;
        repeat (3) @(negedge MCLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL dis_no_resume: got %b expected 0", BUSY); end
        page = 12'($urandom);
        buildExpected(1'b0, page);
        clearCapture();
        pulseRequest(1'b0, 1'b1, page, busySeen);
        waitIdle(5000, to);
        checks++; if (capQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL dis_fresh_count: got %0d expected %0d", capQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < capQ.size(); i++) begin
            checks++;
            if (capQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL dis_fresh_byte%0d: got %h expected %h", i, capQ[i], expQ[i]); end
        end
    endtask

    task automatic test_mrst();
        logic [11:0] page;
        logic        busySeen;
        bit          to;
        page = 12'($urandom);
        clearCapture();
        pulseRequest(1'b1, 1'b0, page, busySeen);
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge MCLK);
            if (nWR === 1'b0 && capQ.size() >= 7) begin
                to = 1'b0;
                break;
            end
        end
        checks++; if (to) begin errors++; $display("[TB] FAIL mrst_strobe_seen: nWR %b expected 0", nWR); end
        MRST = 1'b1;
        @(negedge MCLK);
        checks++; if (nWR !== 1'b1)   begin errors++; $display("[TB] FAIL mrst_nWR: got %b expected 1", nWR); end
        checks++; if (DOEN !== 1'b0)  begin errors++; $display("[TB] FAIL mrst_DOEN: got %b expected 0", DOEN); end
        checks++; if (DOUT !== 8'h00) begin errors++; $display("[TB] FAIL mrst_DOUT: got %h expected 00", DOUT); end
        checks++; if (BUSY !== 1'b0)  begin errors++; $display("[TB] FAIL mrst_BUSY: got %b expected 0", BUSY); end
        MRST = 1'b0;
        repeat (2) @(negedge MCLK);
        page = 12'($urandom);
        buildExpected(1'b1, page);
        clearCapture();
        pulseRequest(1'b1, 1'b0, page, busySeen);
        waitIdle(3000, to);
        checks++; if (capQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL mrst_after_count: got %0d expected %0d", capQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < capQ.size(); i++) begin
            checks++;
            if (capQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL mrst_after_byte%0d: got %h expected %h", i, capQ[i], expQ[i]); end
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        protoErr        = 0;
        MRST            = 1'b1;
        nEN             = 1'b0;
        nFIFOBUFWRCLKEN = 1'b1;
        FIFOBUFWRADDR   = '0;
        FIFOBUFWRDATA   = 1'b0;
        nFIFOSENDBOOT   = 1'b1;
        nFIFOSENDUSER   = 1'b1;
        FIFORELPAGE     = '0;
        nTXE            = 1'b0;

        test_reset();
        test_frames();
        test_txe_stall();
        test_simultaneous();
        test_disable();
        test_mrst();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
